bcd_clock_alarm: RTL and testbench

- Parametrised successor to the team's free-running BCD time-of-day counter.
- Adds:
  - an internal seconds prescaler;
  - run/hold control;
  - 12 h or 24 h display mode;
  - synchronous time load with range validation;
  - an alarm FSM with snooze.
- Feeds the display mux and buzzer driver in the watch top level. All time fields are packed BCD digit pairs.

---
 rtl/bcd_clock_pkg.sv | 54 +++++
 rtl/bcd_time_add_min.sv | 37 +++
 rtl/bcd_clock_alarm.sv | 214 +++++++++++++++++++++
 tb/tb_bcd_clock_alarm.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_clock_pkg.sv
// Shared types and BCD helpers for the time-of-day counter with alarm.
// Hour arithmetic lives here so the time cascade and the snooze adder roll hours the same way.
package bcd_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RINGING,
    ST_SNOOZED
  } alarm_state_e;

  typedef logic [3:0] bcd_t;
  typedef logic [7:0] bcd2_t;

  typedef struct packed {
    logic  pm;
    bcd2_t hh;
  } hour_t;

  localparam bcd_t MAX_SEC_T = 4'd5;
  localparam bcd_t MAX_DIG   = 4'd9;

  function automatic logic bcd_valid(input bcd2_t v);
    return (v[7:4] <= MAX_DIG) && (v[3:0] <= MAX_DIG);
  endfunction

  function automatic logic min_sec_valid(input bcd2_t v);
    return bcd_valid(v) && (v[7:4] <= MAX_SEC_T);
  endfunction

  // Valid BCD compares in the same order as its hex encoding.
  function automatic logic hour_valid(input bcd2_t h, input logic mode24);
    if (!bcd_valid(h)) return 1'b0;
    if (mode24) return h <= 8'h23;
    return (h != 8'h00) && (h <= 8'h12);
  endfunction

  function automatic hour_t hour_inc(input bcd2_t h, input logic pm, input logic mode24);
    hour_t r;
    r.pm = mode24 ? 1'b0 : pm;
    if (mode24 && h == 8'h23)
      r.hh = 8'h00;
    else if (!mode24 && h == 8'h12)
      r.hh = 8'h01;
    else if (h[3:0] == MAX_DIG)
      r.hh = {h[7:4] + 4'd1, 4'd0};
    else
      r.hh = {h[7:4], h[3:0] + 4'd1};
    if (!mode24 && h == 8'h11)
      r.pm = ~pm;
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_add_min.sv
// Combinational hh:mm + ADD_MIN minutes, wrapping through the day with the normal hour roll.
module bcd_time_add_min
  import bcd_clock_pkg::*;
#(
  parameter int ADD_MIN  = 5,
  parameter bit MODE_24H = 1'b1
) (
  input  bcd2_t hh,
  input  bcd2_t mm,
  input  logic  pm,
  output bcd2_t sum_hh,
  output bcd2_t sum_mm,
  output logic  sum_pm
);

  logic [6:0] min_bin;
  logic [6:0] min_raw;
  logic [6:0] min_wrap;
  hour_t      hr;

  // ADD_MIN is at most 59, so the hour carries at most once.
  always_comb begin
    min_bin  = 7'(mm[7:4]) * 7'd10 + 7'(mm[3:0]);
    min_raw  = min_bin + 7'(ADD_MIN);
    min_wrap = min_raw;
    hr.pm    = pm;
    hr.hh    = hh;
    if (min_raw >= 7'd60) begin
      min_wrap = min_raw - 7'd60;
      hr       = hour_inc(hh, pm, MODE_24H);
    end
    sum_mm = {4'(min_wrap / 7'd10), 4'(min_wrap % 7'd10)};
    sum_hh = hr.hh;
    sum_pm = MODE_24H ? 1'b0 : hr.pm;
  end

endmodule

// File: rtl/bcd_clock_alarm.sv
// BCD time-of-day counter with seconds prescaler, validated load and a snoozable alarm.
// Prescaler, seconds/minutes/hours cascade and alarm FSM are all registered here.
module bcd_clock_alarm
  import bcd_clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter bit MODE_24H    = 1'b1,
  parameter int SNOOZE_MIN  = 5,
  parameter int RING_SEC    = 60
) (
  input  logic       clk,
  input  logic       a_reset,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] ld_h,
  input  logic [7:0] ld_m,
  input  logic [7:0] ld_s,
  input  logic       ld_pm,
  input  logic       al_set,
  input  logic       al_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [3:0] h_t,
  output logic [3:0] h_o,
  output logic [3:0] m_t,
  output logic [3:0] m_o,
  output logic [3:0] s_t,
  output logic [3:0] s_o,
  output logic       pm,
  output logic       tick,
  output logic       load_err,
  output logic       ring
);

  localparam int              PW        = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0]   PRESC_TOP = PW'(CLK_PER_SEC - 1);
  localparam bcd2_t           RESET_HH  = MODE_24H ? 8'h00 : 8'h12;
  localparam logic [7:0]      RING_LAST = 8'(RING_SEC - 1);

  logic [PW-1:0] presc;
  bcd2_t         cur_hh, cur_mm, cur_ss;
  logic          cur_pm;
  bcd2_t         al_hh, al_mm;
  logic          al_pm;
  bcd2_t         sn_hh, sn_mm;
  logic          sn_pm;
  bcd2_t         snz_hh, snz_mm;
  logic          snz_pm;
  alarm_state_e  state;
  logic [7:0]    ring_cnt;

  bcd2_t         nxt_ss, nxt_mm;
  hour_t         nxt_hr;
  logic          sec_evt, ld_valid, al_valid, load_ok, al_ok, advance;
  logic          al_hit, sn_hit, ld_pm_eff;

  assign sec_evt   = run && (presc == PRESC_TOP);
  assign ld_valid  = hour_valid(ld_h, MODE_24H) && min_sec_valid(ld_m) && min_sec_valid(ld_s);
  assign al_valid  = hour_valid(ld_h, MODE_24H) && min_sec_valid(ld_m);
  assign load_ok   = load && ld_valid;
  assign al_ok     = al_set && al_valid;
  assign advance   = sec_evt && !load_ok;
  assign ld_pm_eff = MODE_24H ? 1'b0 : ld_pm;

  // Next time if this cycle's second boundary is taken; the digit carries ripple left.
  always_comb begin
    nxt_ss    = cur_ss;
    nxt_mm    = cur_mm;
    nxt_hr.pm = cur_pm;
    nxt_hr.hh = cur_hh;
    if (cur_ss[3:0] != MAX_DIG) begin
      nxt_ss[3:0] = cur_ss[3:0] + 4'd1;
    end else begin
      nxt_ss[3:0] = 4'd0;
      if (cur_ss[7:4] != MAX_SEC_T) begin
        nxt_ss[7:4] = cur_ss[7:4] + 4'd1;
      end else begin
        nxt_ss[7:4] = 4'd0;
        if (cur_mm[3:0] != MAX_DIG) begin
          nxt_mm[3:0] = cur_mm[3:0] + 4'd1;
        end else begin
          nxt_mm[3:0] = 4'd0;
          if (cur_mm[7:4] != MAX_SEC_T) begin
            nxt_mm[7:4] = cur_mm[7:4] + 4'd1;
          end else begin
            nxt_mm[7:4] = 4'd0;
            nxt_hr      = hour_inc(cur_hh, cur_pm, MODE_24H);
          end
        end
      end
    end
  end

  assign al_hit = (nxt_ss == 8'h00) && (nxt_mm == al_mm) && (nxt_hr.hh == al_hh) && (nxt_hr.pm == al_pm);
  assign sn_hit = (nxt_ss == 8'h00) && (nxt_mm == sn_mm) && (nxt_hr.hh == sn_hh) && (nxt_hr.pm == sn_pm);

  bcd_time_add_min #(
    .ADD_MIN (SNOOZE_MIN),
    .MODE_24H(MODE_24H)
  ) u_snooze_add (
    .hh    (cur_hh),
    .mm    (cur_mm),
    .pm    (cur_pm),
    .sum_hh(snz_hh),
    .sum_mm(snz_mm),
    .sum_pm(snz_pm)
  );

  // A valid load overrides a coincident second boundary and restarts the prescaler.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      presc    <= '0;
      cur_hh   <= RESET_HH;
      cur_mm   <= 8'h00;
      cur_ss   <= 8'h00;
      cur_pm   <= 1'b0;
      al_hh    <= RESET_HH;
      al_mm    <= 8'h00;
      al_pm    <= 1'b0;
      tick     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (load_ok) begin
        presc  <= '0;
        cur_hh <= ld_h;
        cur_mm <= ld_m;
        cur_ss <= ld_s;
        cur_pm <= ld_pm_eff;
      end else begin
        if (run) presc <= sec_evt ? '0 : presc + 1'b1;
        if (sec_evt) begin
          cur_ss <= nxt_ss;
          cur_mm <= nxt_mm;
          cur_hh <= nxt_hr.hh;
          cur_pm <= nxt_hr.pm;
        end
      end
      if (al_ok) begin
        al_hh <= ld_h;
        al_mm <= ld_m;
        al_pm <= ld_pm_eff;
      end
      tick     <= advance;
      load_err <= (load && !ld_valid) || (al_set && !al_valid);
    end
  end

  // Alarm FSM; disarming wins over everything, stop wins over snooze.
  always_ff @(posedge clk or negedge a_reset) begin
    if (!a_reset) begin
      state    <= ST_IDLE;
      ring     <= 1'b0;
      ring_cnt <= 8'd0;
      sn_hh    <= RESET_HH;
      sn_mm    <= 8'h00;
      sn_pm    <= 1'b0;
    end else if (!al_en) begin
      state <= ST_IDLE;
      ring  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_ARMED;
        ST_ARMED: begin
          if (advance && al_hit) begin
            state    <= ST_RINGING;
            ring     <= 1'b1;
            ring_cnt <= 8'd0;
          end
        end
        ST_RINGING: begin
          if (stop) begin
            state <= ST_ARMED;
            ring  <= 1'b0;
          end else if (snooze) begin
            state <= ST_SNOOZED;
            ring  <= 1'b0;
            sn_hh <= snz_hh;
            sn_mm <= snz_mm;
            sn_pm <= snz_pm;
          end else if (sec_evt) begin
            if (ring_cnt == RING_LAST) begin
              state <= ST_ARMED;
              ring  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
            end
          end
        end
        ST_SNOOZED: begin
          if (stop) begin
            state <= ST_ARMED;
          end else if (advance && sn_hit) begin
            state    <= ST_RINGING;
            ring     <= 1'b1;
            ring_cnt <= 8'd0;
          end
        end
        default: begin
          state <= ST_IDLE;
          ring  <= 1'b0;
        end
      endcase
    end
  end

  assign h_t = cur_hh[7:4];
  assign h_o = cur_hh[3:0];
  assign m_t = cur_mm[7:4];
  assign m_o = cur_mm[3:0];
  assign s_t = cur_ss[7:4];
  assign s_o = cur_ss[3:0];
  assign pm  = MODE_24H ? 1'b0 : cur_pm;

endmodule

// File: tb/tb_bcd_clock_alarm.sv
// Directed bench for bcd_clock_alarm: a 24 h and a 12 h instance share one stimulus stream.
module tb_bcd_clock_alarm;
  import bcd_clock_pkg::*;

  localparam int CPS  = 4;
  localparam int SNZ  = 5;
  localparam int RSEC = 3;

  logic       clk = 1'b0;
  logic       a_reset = 1'b0;
  logic       run = 1'b0, load = 1'b0, ld_pm = 1'b0;
  logic [7:0] ld_h = 8'h00, ld_m = 8'h00, ld_s = 8'h00;
  logic       al_set = 1'b0, al_en = 1'b0, snooze = 1'b0, stop = 1'b0;

  logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so;
  logic       pm24, tick24, err24, ring24;
  logic [3:0] b_ht, b_ho, b_mt, b_mo, b_st, b_so;
  logic       pm12, tick12, err12, ring12;

  int errors = 0;
  int checks = 0;

  wire [23:0] time24 = {a_ht, a_ho, a_mt, a_mo, a_st, a_so};
  wire [23:0] time12 = {b_ht, b_ho, b_mt, b_mo, b_st, b_so};

  bcd_clock_alarm #(.CLK_PER_SEC(CPS), .MODE_24H(1'b1), .SNOOZE_MIN(SNZ), .RING_SEC(RSEC)) dut24 (
    .clk(clk), .a_reset(a_reset), .run(run), .load(load), .ld_h(ld_h), .ld_m(ld_m), .ld_s(ld_s),
    .ld_pm(ld_pm), .al_set(al_set), .al_en(al_en), .snooze(snooze), .stop(stop),
    .h_t(a_ht), .h_o(a_ho), .m_t(a_mt), .m_o(a_mo), .s_t(a_st), .s_o(a_so),
    .pm(pm24), .tick(tick24), .load_err(err24), .ring(ring24)
  );

  bcd_clock_alarm #(.CLK_PER_SEC(CPS), .MODE_24H(1'b0), .SNOOZE_MIN(SNZ), .RING_SEC(RSEC)) dut12 (
    .clk(clk), .a_reset(a_reset), .run(run), .load(load), .ld_h(ld_h), .ld_m(ld_m), .ld_s(ld_s),
    .ld_pm(ld_pm), .al_set(al_set), .al_en(al_en), .snooze(snooze), .stop(stop),
    .h_t(b_ht), .h_o(b_ho), .m_t(b_mt), .m_o(b_mo), .s_t(b_st), .s_o(b_so),
    .pm(pm12), .tick(tick12), .load_err(err12), .ring(ring12)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                            input logic p, input logic r);
    ld_h  = h;
    ld_m  = m;
    ld_s  = s;
    ld_pm = p;
    run   = r;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    a_reset = 1'b0;
    step_n(2);
    checks++; if (time24 !== 24'h000000) begin errors++; $display("[TB] FAIL reset_time24 got %h want 000000", time24); end
    checks++; if (time12 !== 24'h120000) begin errors++; $display("[TB] FAIL reset_time12 got %h want 120000", time12); end
    checks++; if (pm12 !== 1'b0) begin errors++; $display("[TB] FAIL reset_pm12 got %b want 0", pm12); end
    checks++; if ({tick24, err24, ring24} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags24 got %b want 000", {tick24, err24, ring24}); end
    a_reset = 1'b1;
    step();
  endtask

  task automatic test_wrap_24h();
    apply_load(8'h23, 8'h59, 8'h58, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (tick24 !== ((i % 4) == 0)) begin
        errors++; $display("[TB] FAIL tick_spacing cycle %0d got %b want %b", i, tick24, ((i % 4) == 0));
      end
      if (i == 4) begin
        checks++; if (time24 !== 24'h235959) begin errors++; $display("[TB] FAIL wrap_first got %h want 235959", time24); end
      end
    end
    checks++; if (time24 !== 24'h000000) begin errors++; $display("[TB] FAIL wrap_midnight got %h want 000000", time24); end
    run = 1'b0;
  endtask

  task automatic test_12h_roll();
    apply_load(8'h11, 8'h59, 8'h59, 1'b0, 1'b1);
    step_n(4);
    checks++; if (time12 !== 24'h120000) begin errors++; $display("[TB] FAIL roll_11_12 got %h want 120000", time12); end
    checks++; if (pm12 !== 1'b1) begin errors++; $display("[TB] FAIL roll_11_12_pm got %b want 1", pm12); end
    apply_load(8'h12, 8'h59, 8'h59, 1'b1, 1'b1);
    step_n(4);
    checks++; if (time12 !== 24'h010000) begin errors++; $display("[TB] FAIL roll_12_01 got %h want 010000", time12); end
    checks++; if (pm12 !== 1'b1) begin errors++; $display("[TB] FAIL roll_12_01_pm got %b want 1", pm12); end
    run = 1'b0;
  endtask

  task automatic test_load_err();
    apply_load(8'h24, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++; if (err24 !== 1'b1) begin errors++; $display("[TB] FAIL err_h24_24 got %b want 1", err24); end
    checks++; if (err12 !== 1'b1) begin errors++; $display("[TB] FAIL err_h24_12 got %b want 1", err12); end
    step();
    checks++; if (err24 !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse_width got %b want 0", err24); end
    checks++; if (time24 !== 24'h130000) begin errors++; $display("[TB] FAIL err_keep24 got %h want 130000", time24); end
    apply_load(8'h00, 8'h05, 8'h00, 1'b0, 1'b0);
    checks++; if (err12 !== 1'b1) begin errors++; $display("[TB] FAIL err_h00_12 got %b want 1", err12); end
    checks++; if (err24 !== 1'b0) begin errors++; $display("[TB] FAIL ok_h00_24 got %b want 0", err24); end
    checks++; if (time12 !== 24'h010000 || pm12 !== 1'b1) begin errors++; $display("[TB] FAIL err_keep12 got %h/%b want 010000/1", time12, pm12); end
    checks++; if (time24 !== 24'h000500) begin errors++; $display("[TB] FAIL load_h00_24 got %h want 000500", time24); end
    apply_load(8'h12, 8'h0A, 8'h00, 1'b0, 1'b0);
    checks++; if (err24 !== 1'b1 || err12 !== 1'b1) begin errors++; $display("[TB] FAIL err_digit got %b%b want 11", err24, err12); end
    checks++; if (time24 !== 24'h000500) begin errors++; $display("[TB] FAIL err_digit_keep got %h want 000500", time24); end
    ld_h = 8'h25; ld_m = 8'h00; al_set = 1'b1;
    step();
    al_set = 1'b0;
    checks++; if (err24 !== 1'b1) begin errors++; $display("[TB] FAIL err_alset got %b want 1", err24); end
    step();
  endtask

  task automatic test_alarm_ring();
    ld_h = 8'h07; ld_m = 8'h30; ld_pm = 1'b0; al_set = 1'b1;
    step();
    al_set = 1'b0;
    checks++; if (err24 !== 1'b0) begin errors++; $display("[TB] FAIL alset_ok got %b want 0", err24); end
    al_en = 1'b1;
    step();
    apply_load(8'h07, 8'h30, 8'h00, 1'b0, 1'b0);
    step();
    checks++; if (ring24 !== 1'b0) begin errors++; $display("[TB] FAIL load_equal_no_ring got %b want 0", ring24); end
    apply_load(8'h07, 8'h29, 8'h59, 1'b0, 1'b1);
    step_n(3);
    checks++; if (ring24 !== 1'b0) begin errors++; $display("[TB] FAIL ring_early got %b want 0", ring24); end
    step();
    checks++; if (ring24 !== 1'b1 || time24 !== 24'h073000) begin errors++; $display("[TB] FAIL ring_start got %b/%h want 1/073000", ring24, time24); end
    step_n(11);
    checks++; if (ring24 !== 1'b1) begin errors++; $display("[TB] FAIL ring_hold got %b want 1", ring24); end
    step();
    checks++; if (ring24 !== 1'b0 || time24 !== 24'h073003) begin errors++; $display("[TB] FAIL ring_timeout got %b/%h want 0/073003", ring24, time24); end
    checks++; if (dut24.state !== ST_ARMED) begin errors++; $display("[TB] FAIL ring_timeout_state got %0d want %0d", dut24.state, ST_ARMED); end
  endtask

  task automatic test_snooze();
    int n;
    apply_load(8'h07, 8'h29, 8'h59, 1'b0, 1'b1);
    step_n(4);
    checks++; if (ring24 !== 1'b1) begin errors++; $display("[TB] FAIL snooze_pre_ring got %b want 1", ring24); end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    checks++; if (ring24 !== 1'b0 || dut24.state !== ST_SNOOZED) begin errors++; $display("[TB] FAIL snooze_enter got %b/%0d want 0/%0d", ring24, dut24.state, ST_SNOOZED); end
    n = 0;
    while (ring24 !== 1'b1 && n < 1300) begin
      step();
      n++;
    end
    checks++; if (ring24 !== 1'b1 || time24 !== 24'h073500) begin errors++; $display("[TB] FAIL snooze_wake got %b/%h want 1/073500", ring24, time24); end
    checks++; if (n !== 1199) begin errors++; $display("[TB] FAIL snooze_delay got %0d cycles want 1199", n); end
    stop = 1'b1; snooze = 1'b1;
    step();
    stop = 1'b0; snooze = 1'b0;
    checks++; if (ring24 !== 1'b0 || dut24.state !== ST_ARMED) begin errors++; $display("[TB] FAIL stop_beats_snooze got %b/%0d want 0/%0d", ring24, dut24.state, ST_ARMED); end
  endtask

  task automatic test_load_vs_tick();
    apply_load(8'h10, 8'h20, 8'h30, 1'b0, 1'b1);
    step_n(3);
    apply_load(8'h10, 8'h20, 8'h30, 1'b0, 1'b1);
    checks++; if (tick24 !== 1'b0 || time24 !== 24'h102030) begin errors++; $display("[TB] FAIL load_wins got %b/%h want 0/102030", tick24, time24); end
    step_n(3);
    checks++; if (tick24 !== 1'b0 || time24 !== 24'h102030) begin errors++; $display("[TB] FAIL load_restart got %b/%h want 0/102030", tick24, time24); end
    step();
    checks++; if (tick24 !== 1'b1 || time24 !== 24'h102031) begin errors++; $display("[TB] FAIL load_next_tick got %b/%h want 1/102031", tick24, time24); end
  endtask

  task automatic test_reset_mid_ring();
    apply_load(8'h07, 8'h29, 8'h59, 1'b0, 1'b1);
    step_n(4);
    checks++; if (ring24 !== 1'b1 || tick24 !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset got %b%b want 11", ring24, tick24); end
    #2 a_reset = 1'b0;
    #1;
    checks++; if (ring24 !== 1'b0 || tick24 !== 1'b0 || time24 !== 24'h000000) begin errors++; $display("[TB] FAIL async_reset24 got %b%b/%h want 00/000000", ring24, tick24, time24); end
    checks++; if (time12 !== 24'h120000 || ring12 !== 1'b0) begin errors++; $display("[TB] FAIL async_reset12 got %h/%b want 120000/0", time12, ring12); end
    checks++; if (dut24.state !== ST_IDLE) begin errors++; $display("[TB] FAIL async_reset_state got %0d want %0d", dut24.state, ST_IDLE); end
    step_n(2);
    a_reset = 1'b1;
    run = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_wrap_24h();
    test_12h_roll();
    test_load_err();
    test_alarm_ring();
    test_snooze();
    test_load_vs_tick();
    test_reset_mid_ring();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
